// File: rtl/nn_config_pkg.sv
// ---------------------------------------------------------------------------
// nn_config_pkg
// Shared configuration for the neural-network datapath blocks.
//   DEFAULT_DATA_WIDTH : default width of one activation word
//   DEFAULT_NUM_NEURON : default number of parallel neuron lanes per layer
//   ser_state_t        : state encoding of the layer output serializer
// ---------------------------------------------------------------------------
package nn_config_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_NUM_NEURON = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STREAM  = 2'd2
    } ser_state_t;

endpackage : nn_config_pkg

// File: rtl/layer_output_serializer.sv
// ---------------------------------------------------------------------------
// layer_output_serializer
// Collects one result from each of num_neuron parallel neuron lanes (lanes
// may finish in any order, in the same or different cycles) and then streams
// the captured words lane 0 .. num_neuron-1, one per cycle, to the next layer.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   neuron_data  : packed lane words, lane i at [i*data_width +: data_width]
//   neuron_valid : per-lane single-cycle result strobe
//   out_data     : serialized word (registered, holds when out_valid=0)
//   out_valid    : qualifies out_data (registered)
//   busy         : high while collecting or streaming (registered)
//   overrun      : sticky; a lane result arrived while streaming and was lost
// ---------------------------------------------------------------------------
module layer_output_serializer
    import nn_config_pkg::*;
#(
    parameter int unsigned num_neuron = DEFAULT_NUM_NEURON,
    parameter int unsigned data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [num_neuron*data_width-1:0] neuron_data,
    input  logic [num_neuron-1:0]            neuron_valid,
    output logic [data_width-1:0]            out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned    IDX_W    = (num_neuron > 1) ? $clog2(num_neuron) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_neuron - 1);

    ser_state_t              state_q, state_d;
    logic [num_neuron-1:0]   mask_q, mask_d;
    logic [num_neuron-1:0]   merged;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [data_width-1:0]   buf_q [num_neuron];
    logic [data_width-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    capture_en;

    // Lanes captured so far plus those arriving this cycle; completion is
    // judged on this so every lane may finish in the same cycle.
    assign merged     = mask_q | neuron_valid;
    assign capture_en = (state_q != STREAM);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (&merged) begin
                    state_d = STREAM;
                end else if (|merged) begin
                    state_d = COLLECT;
                end
            end
            STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        mask_d      = mask_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        busy_d      = (state_d != IDLE);
        overrun_d   = overrun_q;
        case (state_q)
            IDLE, COLLECT: begin
                mask_d = merged;
            end
            STREAM: begin
                out_valid_d = 1'b1;
                out_data_d  = buf_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    mask_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                // Results cannot be accepted while the buffer is being read
                // out, including on the final beat.
                if (|neuron_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                mask_d = '0;
                idx_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture buffer (no reset: contents are only read after the mask
    // shows every lane has been written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < num_neuron; i++) begin
            if (capture_en && neuron_valid[i]) begin
                buf_q[i] <= neuron_data[i*data_width +: data_width];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule : layer_output_serializer

// File: tb/tb_layer_output_serializer.sv
// ---------------------------------------------------------------------------
// tb_layer_output_serializer
// Directed bench for layer_output_serializer with 4 lanes of 16 bits.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each check sees the registers as updated by the preceding edge.
// ---------------------------------------------------------------------------
module tb_layer_output_serializer;

    localparam int unsigned NN = 4;
    localparam int unsigned DW = 16;

    logic               clk;
    logic               rst;
    logic [NN*DW-1:0]   neuron_data;
    logic [NN-1:0]      neuron_valid;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int unsigned errors;
    int unsigned checks;

    layer_output_serializer #(
        .num_neuron (NN),
        .data_width (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_data  (neuron_data),
        .neuron_valid (neuron_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NN-1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        neuron_valid = v;
        neuron_data  = {d3, d2, d1, d0};
    endtask

    // Four edges, each must present the next lane word with out_valid high.
    task automatic expect_stream(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3);
        logic [63:0] words;
        words = {w3, w2, w1, w0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(words[i*16 +: 16]));
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        neuron_valid = '0;
        neuron_data  = '0;

        // Reset state
        #2;
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Aligned: all lanes in one cycle
        drive(4'b1111, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("al_busyE", 32'(busy), 32'd1);
        check("al_validE", 32'(out_valid), 32'd0);
        expect_stream("al", 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        check("al_busy_end", 32'(busy), 32'd0);
        tick();
        check("al_valid_off", 32'(out_valid), 32'd0);
        check("al_data_hold", 32'(out_data), 32'h0404);

        // Skewed: lanes 0,2 at cycle 1, lane 3 at cycle 3, lane 1 at cycle 5
        drive(4'b0101, 16'hA000, 16'hDEAD, 16'hA002, 16'hBEEF);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("sk_busy1", 32'(busy), 32'd1);
        tick();
        drive(4'b1000, 16'h5555, 16'h6666, 16'h7777, 16'hA003);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("sk_busy3", 32'(busy), 32'd1);
        check("sk_valid3", 32'(out_valid), 32'd0);
        tick();
        drive(4'b0010, 16'h1234, 16'hA001, 16'h4321, 16'h9999);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("sk_valid5", 32'(out_valid), 32'd0);
        expect_stream("sk", 16'hA000, 16'hA001, 16'hA002, 16'hA003);
        tick();
        check("sk_valid_off", 32'(out_valid), 32'd0);

        // Overwrite: lane 0 rewritten before completion
        drive(4'b0001, 16'h1111, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'b0001, 16'h2222, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'b1110, 16'h9999, 16'h3333, 16'h4444, 16'h5555);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        expect_stream("ow", 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        tick();
        check("ow_ovr", 32'(overrun), 32'd0);

        // Overrun during the second stream cycle
        drive(4'b1111, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        check("or_data0", 32'(out_data), 32'h0A0A);
        check("or_ovr_pre", 32'(overrun), 32'd0);
        drive(4'b0001, 16'h7FFF, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("or_data1", 32'(out_data), 32'h0B0B);
        check("or_ovr_set", 32'(overrun), 32'd1);
        tick();
        check("or_data2", 32'(out_data), 32'h0C0C);
        tick();
        check("or_data3", 32'(out_data), 32'h0D0D);
        check("or_busy_end", 32'(busy), 32'd0);
        tick();
        check("or_valid_off", 32'(out_valid), 32'd0);
        check("or_ovr_sticky", 32'(overrun), 32'd1);
        // Mask must be empty: a single lane only enters COLLECT
        drive(4'b0001, 16'h0E00, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("or_mask_busy", 32'(busy), 32'd1);
        tick();
        check("or_mask_nostream", 32'(out_valid), 32'd0);
        drive(4'b1110, 16'h0, 16'h0E01, 16'h0E02, 16'h0E03);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        expect_stream("or2", 16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03);
        check("or_ovr_still", 32'(overrun), 32'd1);
        tick();

        // Reset mid-stream after two words
        drive(4'b1111, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        check("rs_word1", 32'(out_data), 32'hB001);
        rst = 1'b1;
        #1;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_ovr", 32'(overrun), 32'd0);
        check("rs_data", 32'(out_data), 32'h0);
        tick();
        rst = 1'b0;
        drive(4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("rs_busy_cap", 32'(busy), 32'd1);
        expect_stream("rs", 16'hC000, 16'hC001, 16'hC002, 16'hC003);
        tick();
        check("rs_valid_off", 32'(out_valid), 32'd0);

        // Valid on the final stream edge: dropped, flagged, lane not captured
        drive(4'b1111, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        tick();
        check("fe_data2", 32'(out_data), 32'hD002);
        check("fe_ovr_pre", 32'(overrun), 32'd0);
        drive(4'b0100, 16'h0, 16'h0, 16'hEEEE, 16'h0);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("fe_data3", 32'(out_data), 32'hD003);
        check("fe_ovr_set", 32'(overrun), 32'd1);
        check("fe_busy_end", 32'(busy), 32'd0);
        tick();
        drive(4'b1011, 16'hF000, 16'hF001, 16'h0, 16'hF003);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        check("fe_collect", 32'(busy), 32'd1);
        tick();
        check("fe_nostream", 32'(out_valid), 32'd0);
        drive(4'b0100, 16'h0, 16'h0, 16'hF002, 16'h0);
        tick();
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        expect_stream("fe", 16'hF000, 16'hF001, 16'hF002, 16'hF003);
        tick();
        check("fe_valid_off", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_layer_output_serializer
